// File: rtl/pipe_pkg.sv
// pipe_pkg
// Shared definitions for the pipeline stage registers of the datapath:
//   - FSM state encoding for pipe_stage_ctrl (the code equals the entry count)
//   - payload widths of the four inter-stage bundles
//   - default stall counter width
//   - reg_op_t: per-cycle operation applied to a data register
package pipe_pkg;

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    localparam int IFID_W    = 64;   // PC + instruction
    localparam int IDEX_W    = 138;  // PC, two operands, immediate, control
    localparam int EXMEM_W   = 129;  // next PC, operand 2, jump target, ALU result, ALU flag
    localparam int MEMWB_W   = 71;   // load data, ALU result, rd/write-enable
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        REG_HOLD      = 2'd0,
        REG_LOAD_IN   = 2'd1,
        REG_LOAD_SKID = 2'd2,
        REG_CLEAR     = 2'd3
    } reg_op_t;

endpackage

// File: rtl/pipe_stage_ctrl.sv
// pipe_stage_ctrl
// Handshake FSM, data-register load controls and saturating stall counter
// for pipe_stage_reg. Holds no payload.
//
// Build option: PIPE_STAGE_SKID_EN enables the second (skid) entry.
//
// state   | meaning
// --------+---------------------------------------------
// S_EMPTY | no entry held
// S_ONE   | main register valid, presented downstream
// S_FULL  | main and skid valid (skid build only)
//
// Ports:
//   clock, clear_n     clock, async active-low reset
//   flush              synchronous squash of all held entries
//   in_valid/in_ready  upstream handshake
//   out_valid          stage presents an entry (register decode)
//   out_ready          downstream accepts
//   occupancy          entries held
//   main_op, skid_op   operation for the main / skid data register
//   stall_count        saturating count of out_valid & !out_ready cycles
module pipe_stage_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             out_ready,
    output logic             in_ready,
    output logic             out_valid,
    output logic [1:0]       occupancy,
    output reg_op_t          main_op,
`ifdef PIPE_STAGE_SKID_EN
    output reg_op_t          skid_op,
`endif
    output logic [CNT_W-1:0] stall_count
);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             in_fire, out_fire;

    always_comb begin
        out_valid = (state_q != S_EMPTY);
`ifdef PIPE_STAGE_SKID_EN
        in_ready  = (state_q != S_FULL);
`else
        // Without the skid entry a held payload can only be replaced when it
        // leaves in the same cycle, so ready passes through from downstream.
        in_ready  = !out_valid || out_ready;
`endif
        in_fire   = in_valid && in_ready;
        out_fire  = out_valid && out_ready;

        state_d = state_q;
        main_op = REG_HOLD;
`ifdef PIPE_STAGE_SKID_EN
        skid_op = REG_HOLD;
`endif
        if (flush) begin
            state_d = S_EMPTY;
            main_op = REG_CLEAR;
`ifdef PIPE_STAGE_SKID_EN
            skid_op = REG_CLEAR;
`endif
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (in_fire) begin
                        main_op = REG_LOAD_IN;
                        state_d = S_ONE;
                    end
                end
                S_ONE: begin
                    if (in_fire && out_fire) begin
                        main_op = REG_LOAD_IN;
                    end else if (out_fire) begin
                        // zero on leaving so out_data reads 0 while empty
                        main_op = REG_CLEAR;
                        state_d = S_EMPTY;
`ifdef PIPE_STAGE_SKID_EN
                    end else if (in_fire) begin
                        skid_op = REG_LOAD_IN;
                        state_d = S_FULL;
`endif
                    end
                end
`ifdef PIPE_STAGE_SKID_EN
                S_FULL: begin
                    if (out_fire) begin
                        main_op = REG_LOAD_SKID;
                        skid_op = REG_CLEAR;
                        state_d = S_ONE;
                    end
                end
`endif
                default: begin
                    state_d = S_EMPTY;
                    main_op = REG_CLEAR;
`ifdef PIPE_STAGE_SKID_EN
                    skid_op = REG_CLEAR;
`endif
                end
            endcase
        end

        stall_d = stall_q;
        if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= S_EMPTY;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
        end
    end

    // state code equals number of entries held
    assign occupancy   = state_q;
    assign stall_count = stall_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
// Flow-controlled inter-stage register carrying an opaque DATA_W payload
// with valid/ready handshake, synchronous flush and a saturating stall
// counter. Control lives in pipe_stage_ctrl; this file holds the data
// registers.
//
// Build option: PIPE_STAGE_SKID_EN adds a skid entry so in_ready is a pure
// register decode; without it in_ready depends combinationally on out_ready.
//
// Ports:
//   clock, clear_n      clock, async active-low reset
//   flush               synchronous squash
//   in_valid, in_ready, in_data     upstream side
//   out_valid, out_ready, out_data  downstream side
//   occupancy           entries held (0..2)
//   stall_count         cycles with out_valid=1 and out_ready=0 (saturating)
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = EXMEM_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clock,
    input  logic              clear_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_count
);

    reg_op_t           main_op;
    logic [DATA_W-1:0] main_q, main_d;
`ifdef PIPE_STAGE_SKID_EN
    reg_op_t           skid_op;
    logic [DATA_W-1:0] skid_q, skid_d;
`endif

    pipe_stage_ctrl #(
        .CNT_W (CNT_W)
    ) u_ctrl (
        .clock       (clock),
        .clear_n     (clear_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .out_ready   (out_ready),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .occupancy   (occupancy),
        .main_op     (main_op),
`ifdef PIPE_STAGE_SKID_EN
        .skid_op     (skid_op),
`endif
        .stall_count (stall_count)
    );

    always_comb begin
        case (main_op)
            REG_LOAD_IN:   main_d = in_data;
`ifdef PIPE_STAGE_SKID_EN
            REG_LOAD_SKID: main_d = skid_q;
`endif
            REG_CLEAR:     main_d = '0;
            default:       main_d = main_q;
        endcase
`ifdef PIPE_STAGE_SKID_EN
        case (skid_op)
            REG_LOAD_IN:   skid_d = in_data;
            REG_CLEAR:     skid_d = '0;
            default:       skid_d = skid_q;
        endcase
`endif
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            main_q <= '0;
`ifdef PIPE_STAGE_SKID_EN
            skid_q <= '0;
`endif
        end else begin
            main_q <= main_d;
`ifdef PIPE_STAGE_SKID_EN
            skid_q <= skid_d;
`endif
        end
    end

    assign out_data = main_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg
// Directed bench for pipe_stage_reg (DATA_W=129, CNT_W=4). Follows the
// PIPE_STAGE_SKID_EN setting of the build for the backpressure section.
module tb_pipe_stage_reg;

    localparam int DW = 129;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          clear_n, flush, in_valid, out_ready;
    logic [DW-1:0] in_data;
    logic          in_ready, out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
    logic [CW-1:0] stall_count;

    int errors = 0;
    int checks = 0;

    pipe_stage_reg #(
        .DATA_W (DW),
        .CNT_W  (CW)
    ) dut (
        .clock       (clock),
        .clear_n     (clear_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .occupancy   (occupancy),
        .stall_count (stall_count)
    );

    always #5 clock = ~clock;

    // payload touching both ends of the 129-bit bus
    function automatic logic [DW-1:0] pl(input int v);
        return (DW'(v) << 100) | DW'(v);
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #2;
    endtask

    initial begin
        clear_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        #3;
        chk("rst_out_valid", DW'(out_valid), DW'(0));
        chk("rst_out_data",  out_data, '0);
        chk("rst_in_ready",  DW'(in_ready), DW'(1));
        chk("rst_occupancy", DW'(occupancy), DW'(0));
        chk("rst_stall",     DW'(stall_count), DW'(0));
        tick;
        clear_n = 1'b1;

        // streaming at full rate
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = pl(i);
            tick;
            chk("stream_data",     out_data, pl(i));
            chk("stream_valid",    DW'(out_valid), DW'(1));
            chk("stream_in_ready", DW'(in_ready), DW'(1));
        end
        in_valid = 1'b0;
        in_data  = '0;
        tick;
        chk("drain_valid", DW'(out_valid), DW'(0));
        chk("drain_data",  out_data, '0);
        chk("drain_occ",   DW'(occupancy), DW'(0));
        chk("drain_stall", DW'(stall_count), DW'(0));

`ifdef PIPE_STAGE_SKID_EN
        // backpressure into the skid entry
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = pl(16'hA);
        tick;
        in_data   = pl(16'hB);
        tick;
        chk("bp_occ2",     DW'(occupancy), DW'(2));
        chk("bp_in_ready", DW'(in_ready), DW'(0));
        chk("bp_head_a",   out_data, pl(16'hA));
        in_valid = 1'b0;
        tick;
        chk("bp_hold_a",   out_data, pl(16'hA));
        chk("bp_hold_occ", DW'(occupancy), DW'(2));
        out_ready = 1'b1;
        tick;
        chk("bp_then_b",   out_data, pl(16'hB));
        chk("bp_ready_up", DW'(in_ready), DW'(1));
        chk("bp_occ1",     DW'(occupancy), DW'(1));
        tick;
        chk("bp_empty",    DW'(out_valid), DW'(0));
        chk("bp_zero",     out_data, '0);
        chk("bp_stall",    DW'(stall_count), DW'(2));

        // flush while full, with a payload offered the same cycle
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = pl(16'hD);
        tick;
        in_data   = pl(16'hE);
        tick;
        chk("fl_pre_occ", DW'(occupancy), DW'(2));
        flush   = 1'b1;
        in_data = pl(16'hC);
        tick;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", DW'(out_valid), DW'(0));
        chk("fl_occ",   DW'(occupancy), DW'(0));
        chk("fl_data",  out_data, '0);
        tick;
        chk("fl_no_c_valid", DW'(out_valid), DW'(0));
        chk("fl_no_c_data",  out_data, '0);

        // fill to two entries ahead of the reset check
        in_valid = 1'b1;
        in_data  = pl(16'hF);
        tick;
        in_data  = pl(16'h10);
        tick;
        in_valid = 1'b0;
        chk("pre_rst_occ", DW'(occupancy), DW'(2));
`else
        // no skid: in_ready follows out_ready while an entry is held
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = pl(16'hA);
        tick;
        in_data   = pl(16'hB);
        #1;
        chk("ns_ready_lo0", DW'(in_ready), DW'(0));
        chk("ns_head_a",    out_data, pl(16'hA));
        tick;
        chk("ns_hold_a",    out_data, pl(16'hA));
        chk("ns_occ1a",     DW'(occupancy), DW'(1));
        chk("ns_stall1",    DW'(stall_count), DW'(1));
        out_ready = 1'b1;
        #1;
        chk("ns_ready_hi",  DW'(in_ready), DW'(1));
        tick;
        chk("ns_data_b",    out_data, pl(16'hB));
        chk("ns_occ1b",     DW'(occupancy), DW'(1));
        chk("ns_stall1b",   DW'(stall_count), DW'(1));
        out_ready = 1'b0;
        #1;
        chk("ns_ready_lo1", DW'(in_ready), DW'(0));
        tick;
        chk("ns_hold_b",    out_data, pl(16'hB));
        chk("ns_occ1c",     DW'(occupancy), DW'(1));
        chk("ns_stall2",    DW'(stall_count), DW'(2));
        out_ready = 1'b1;
        in_valid  = 1'b0;
        tick;
        chk("ns_empty",     DW'(out_valid), DW'(0));
        chk("ns_zero",      out_data, '0);
        chk("ns_occ0",      DW'(occupancy), DW'(0));

        // flush discards a same-cycle input fire
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = pl(16'hD);
        tick;
        out_ready = 1'b1;
        flush     = 1'b1;
        in_data   = pl(16'hC);
        #1;
        chk("fl_in_ready", DW'(in_ready), DW'(1));
        tick;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", DW'(out_valid), DW'(0));
        chk("fl_occ",   DW'(occupancy), DW'(0));
        chk("fl_data",  out_data, '0);
        chk("fl_stall_kept", DW'(stall_count), DW'(2));
        tick;
        chk("fl_no_c_valid", DW'(out_valid), DW'(0));
        chk("fl_no_c_data",  out_data, '0);

        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = pl(16'hF);
        tick;
        in_valid  = 1'b0;
        chk("pre_rst_occ", DW'(occupancy), DW'(1));
`endif

        // asynchronous reset while holding entries
        clear_n = 1'b0;
        #1;
        chk("mid_rst_valid", DW'(out_valid), DW'(0));
        chk("mid_rst_data",  out_data, '0);
        chk("mid_rst_ready", DW'(in_ready), DW'(1));
        chk("mid_rst_occ",   DW'(occupancy), DW'(0));
        chk("mid_rst_stall", DW'(stall_count), DW'(0));
        tick;
        clear_n = 1'b1;

        // stall counter saturation at 2^4-1
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = pl(16'h11);
        tick;
        in_valid  = 1'b0;
        chk("sat_start", DW'(stall_count), DW'(0));
        repeat (14) tick;
        chk("sat_14", DW'(stall_count), DW'(14));
        repeat (6) tick;
        chk("sat_15",   DW'(stall_count), DW'(15));
        chk("sat_data", out_data, pl(16'h11));
        flush = 1'b1;
        tick;
        flush = 1'b0;
        chk("sat_after_flush", DW'(stall_count), DW'(15));
        chk("sat_flush_valid", DW'(out_valid), DW'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, flow-controlled pipeline stage register that replaces the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) of the pipelined datapath. It carries an opaque DATA_W-bit payload with a valid/ready handshake, a synchronous flush for branch/hazard squashing, and an optional two-entry skid buffer so that stalls from downstream do not create a combinational ready path upstream. It also keeps a saturating stall counter for hazard-unit debugging.

## Interface
- DATA_W, 129, payload width; 129 is the EX/MEM bundle (next PC, operand 2, jump target, ALU result, ALU flag).
- CNT_W, 16, stall counter width.
- clock  in  1  single clock; all state updates on posedge.
- clear_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous squash; highest priority after reset.
- in_valid  in  1  upstream has a payload.
- in_ready  out  1  stage accepts a payload this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  stage holds a payload for downstream.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  DATA_W  payload presented downstream.
- occupancy  out  2  entries held (0, 1, or 2).
- stall_count  out  CNT_W  cycles with out_valid=1 and out_ready=0.

## Operation
- Input fire: in_valid & in_ready. Output fire: out_valid & out_ready.
- FSM states: S_EMPTY (0 entries), S_ONE (main register valid), S_FULL (main and skid valid).
- S_EMPTY: in_ready=1. Input fire -> main<=in_data, go to S_ONE.
- S_ONE: in_ready=1, out_valid=1, out_data=main.
  - Input and output fire -> main<=in_data, stay in S_ONE.
  - Input fire only -> skid<=in_data, go to S_FULL.
  - Output fire only -> go to S_EMPTY.
- S_FULL: in_ready=0, out_data=main. Output fire -> main<=skid, go to S_ONE. Order is preserved: skid is never presented ahead of main.
- flush=1: go to S_EMPTY, main and skid <= 0. A same-cycle input fire is discarded. The same-cycle output fire still counts downstream, because out_valid was 1 that cycle.
- out_data is all-zero whenever out_valid=0, since data registers are zeroed on leaving state.
- stall_count: +1 on each cycle with out_valid & !out_ready. Saturates at 2^CNT_W-1. Cleared only by clear_n; flush does not clear it.
- Reset (clear_n=0, asynchronous): state S_EMPTY, main=0, skid=0, stall_count=0. Outputs in_ready=1, out_valid=0, out_data=0, occupancy=0.

## Timing
- Latency: in_data accepted at edge N appears on out_data after edge N, i.e. in cycle N+1.
- Full throughput (one payload per cycle) while out_ready=1.
- in_ready is a pure register decode (state != S_FULL); it has no combinational dependence on out_ready.
- out_valid, out_data and occupancy are register outputs.
- Reset asserted mid-transfer drops all held entries immediately. Deassertion is taken synchronously to clock by the integrator.

## Configuration
- PIPE_STAGE_SKID_EN defined: two-entry skid behaviour as above.
- PIPE_STAGE_SKID_EN undefined: the skid register and S_FULL are removed.
  - in_ready = !out_valid | out_ready, which is combinational from out_ready.
  - S_ONE with input fire and no output fire cannot occur.
  - occupancy never exceeds 1.
  - Latency, flush, reset and stall_count behaviour are unchanged.

## Structure
- Shared package pipe_pkg holds:
  - state encoding: S_EMPTY=2'd0, S_ONE=2'd1, S_FULL=2'd2;
  - payload width constants: IFID_W, IDEX_W, EXMEM_W=129, MEMWB_W;
  - default CNT_W.
- One sub-module, pipe_stage_ctrl: the FSM, handshake decode, load enables for main and skid, and the stall counter.
- The data registers and output mux stay in pipe_stage_reg.

## Test plan
- Reset: clear_n=0 mid-stream with occupancy=2 -> immediately out_valid=0, out_data=0, in_ready=1, occupancy=0, stall_count=0.
- Streaming: out_ready=1, payloads 1..8 on consecutive cycles -> out_data 1..8 on consecutive cycles, each one cycle after acceptance; in_ready stays 1.
- Backpressure (skid enabled): out_ready=0 while sending A then B -> occupancy=2 and in_ready=0 after B. Then out_ready=1 -> A then B delivered in order, and in_ready returns to 1 after A departs. stall_count reads 2.
- Flush: occupancy=2 and flush=1 with in_valid=1 carrying C -> next cycle out_valid=0, occupancy=0, out_data=0, and C never appears.
- Saturation: CNT_W=4, out_ready=0 for 20 cycles with a payload held -> stall_count=15.
- Skid disabled: out_ready toggles 0/1 with in_valid=1 -> in_ready follows out_ready in the same cycle while full, and occupancy never exceeds 1.
